mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core. It sits beside the E-stage ALU and runs the execution of mult/multu/div/divu. It owns the HI/LO registers and serves mthi/mtlo/mfhi/mflo. It exports a busy-based stall request that the hazard controller ORs into its PC/D-stage freeze and E-stage clear.

## Interface
- MULT_CYCLES, 5: busy cycles after issue for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles after issue for div/divu (≥1).
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage holds a valid MD-class instruction this cycle.
- md_op  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; others treated as NONE.
- a  input  32  forwarded rs operand (E stage).
- b  input  32  forwarded rt operand (E stage).
- md_d  input  1  D-stage instruction is MD-class (any nonzero md_op).
- rdata  output  32  mfhi→hi, mflo→lo, otherwise 0; combinational.
- busy  output  1  operation in flight or being issued this cycle.
- stall_md  output  1  md_d & busy; to hazard controller.
- hi, lo  output  32  architectural HI/LO.

## Operation
- States: IDLE, RUN. A 4-bit down-counter cnt and 32-bit shadow registers hi_t and lo_t.
- IDLE and start with MULT/MULTU/DIV/DIVU/MADD*/MSUB*:
  - compute the result from a and b into hi_t and lo_t;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- MULT: signed 64-bit product. MULTU: unsigned 64-bit product. hi_t holds the upper word and lo_t the lower word.
- DIV/DIVU: lo_t = quotient, hi_t = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero: lo_t = 0xFFFFFFFF, hi_t = a.
- Signed 0x80000000 / 0xFFFFFFFF: lo_t = 0x80000000, hi_t = 0.
- MADD*/MSUB*: {hi_t, lo_t} = {hi, lo} ± the 64-bit product, mod 2^64. Uses MULT_CYCLES.
- RUN: cnt decrements each edge. On the edge where cnt==1: hi←hi_t, lo←lo_t, state→IDLE.
- MTHI/MTLO in IDLE: write a into hi or lo on the next edge. No busy.
- MFHI/MFLO: read-only via rdata. No state change.
- start while in RUN: the hazard controller guarantees this cannot happen. If it occurs anyway, it is ignored, and the in-flight result and counter are unaffected.
- busy = (state==RUN) | (start & op ∈ {MULT, MULTU, DIV, DIVU, MADD*, MSUB*}).

## Timing
- Reset (async assert): state IDLE, cnt 0, hi_t/lo_t/hi/lo 0, busy 0, stall_md 0, rdata 0 (md_op permitting).
- Reset asserted mid-RUN discards the pending result. HI/LO return to 0.
- Multiply/divide latency:
  - cycle 0: issue, with busy=1 combinationally;
  - cycles 1..N: RUN, busy=1;
  - edge ending cycle N: commit;
  - cycle N+1: busy=0 and the new hi/lo are visible.
- busy is therefore high for N+1 consecutive cycles.
- An MD instruction in D during any busy cycle is held. It enters E no earlier than cycle N+1, so mfhi then reads the committed value.
- mthi/mtlo: hi/lo updated at the edge ending the issue cycle. An mfhi/mflo in E the following cycle sees the new value.
- rdata is purely combinational from md_op, hi and lo. It has no internal bypass from hi_t/lo_t.

## Configuration
- MDU_MADD_EN defined: ops 9–12 are decoded as above.
- MDU_MADD_EN undefined:
  - ops 9–12 are treated as NONE: no busy, no state change;
  - the accumulate adder/subtractor is not built.

## Structure
- Shared package holds:
  - the md_op encoding constants (MD_NONE … MD_MSUBU);
  - the state encoding (ST_IDLE, ST_RUN);
  - default cycle counts.
- These constants are reused by the D/E/M/W controller decode and the hazard controller.
- Sub-module mdu_arith: combinational 64-bit multiply, divide and accumulate datapath that produces {hi_t, lo_t} from op, a, b, hi and lo. mdu_ctrl holds only the FSM, counter and registers.

## Test plan
- Reset mid-RUN: issue div, assert reset in cycle 3 → hi=lo=0, busy=0 immediately. No commit occurs after release.
- MULT: a=0xFFFFFFFE (−2), b=3 → busy high 6 cycles. Cycle 6 shows hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - a=−7, b=2 → after 11 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - a=7, b=0 → lo=0xFFFFFFFF, hi=7;
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall: issue mult, hold md_d=1 → stall_md=1 for exactly 6 cycles, then 0. With md_d=0, stall_md stays 0 throughout.
- MTHI/MFHI: mthi a=0x12345678, then md_op=MFHI next cycle → rdata=0x12345678. Ignored start during RUN: hi/lo equal the first op's result only.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0 after 6 cycles. Without the macro, same stimulus → busy stays 0 and hi/lo are unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MD-class op encoding, FSM states and default latencies for mdu_ctrl and the hazard logic.
// Optional MADD/MSUB decode is controlled by the MDU_MADD_EN macro.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that occupy the unit for multiple cycles and commit through hi_t/lo_t.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide/accumulate datapath producing {hi_t, lo_t}.
// Accumulate paths exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi_t,
  output logic [31:0] o_lo_t
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_sgn;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_res;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_sgn   = (i_op == MD_DIV);
  assign w_mag_a = (w_sgn && i_a[31]) ? -i_a : i_a;
  assign w_mag_b = (w_sgn && i_b[31]) ? -i_b : i_b;
  assign w_div_b = (i_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_div_b;
  assign w_ur    = w_mag_a % w_div_b;
  assign w_q     = (w_sgn && (i_a[31] ^ i_b[31])) ? -w_uq : w_uq;
  assign w_r     = (w_sgn && i_a[31]) ? -w_ur : w_ur;

`ifndef MDU_MADD_EN
  logic w_unused_acc;
  assign w_unused_acc = ^{i_hi, i_lo};
`endif

  always_comb begin
    w_res = 64'd0;
    case (i_op)
      MD_MULT:          w_res = w_prod_s;
      MD_MULTU:         w_res = w_prod_u;
      MD_DIV, MD_DIVU:  w_res = (i_b == 32'd0) ? {i_a, 32'hFFFF_FFFF} : {w_r, w_q};
`ifdef MDU_MADD_EN
      MD_MADD:          w_res = {i_hi, i_lo} + w_prod_s;
      MD_MADDU:         w_res = {i_hi, i_lo} + w_prod_u;
      MD_MSUB:          w_res = {i_hi, i_lo} - w_prod_s;
      MD_MSUBU:         w_res = {i_hi, i_lo} - w_prod_u;
`endif
      default:          w_res = 64'd0;
    endcase
  end

  assign o_hi_t = w_res[63:32];
  assign o_lo_t = w_res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: issue/RUN FSM, latency counter, HI/LO and busy-based stall.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_md_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_md_d,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_stall_md,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi_t;
  logic [31:0] r_lo_t;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_hi_t;
  logic [31:0] w_lo_t;
  logic        w_issue;
  logic [3:0]  w_cycles;

  mdu_arith u_arith (
    .i_op   (i_md_op),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .o_hi_t (w_hi_t),
    .o_lo_t (w_lo_t)
  );

  assign w_issue  = i_start && is_long_op(i_md_op);
  assign w_cycles = is_div_op(i_md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Starts arriving during RUN are dropped; the in-flight result stays intact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_hi_t  <= 32'd0;
      r_lo_t  <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_hi_t  <= w_hi_t;
            r_lo_t  <= w_lo_t;
            r_cnt   <= w_cycles;
            r_state <= ST_RUN;
          end else if (i_start && (i_md_op == MD_MTHI)) begin
            r_hi <= i_a;
          end else if (i_start && (i_md_op == MD_MTLO)) begin
            r_lo <= i_a;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_hi_t;
            r_lo    <= r_lo_t;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy     = (r_state == ST_RUN) || w_issue;
  assign o_stall_md = i_md_d && o_busy;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

  always_comb begin
    o_rdata = 32'd0;
    if (i_md_op == MD_MFHI) o_rdata = r_hi;
    else if (i_md_op == MD_MFLO) o_rdata = r_lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_d;
  logic [31:0] rdata;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_md_op    (md_op),
    .i_a        (a),
    .i_b        (b),
    .i_md_d     (md_d),
    .o_rdata    (rdata),
    .o_busy     (busy),
    .o_stall_md (stall_md),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_long(input logic [3:0] op);
    bit r;
    r = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
    r = r || ((op >= 4'd9) && (op <= 4'd12));
`endif
    return r;
  endfunction

  // Result as {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0] acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'(x);
    uy  = longint'(y);
    acc = {h, l};
    case (op)
      4'd1: return sx * sy;
      4'd2: return ux * uy;
      4'd3, 4'd4: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (op == 4'd4) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd9:  return acc + (sx * sy);
      4'd10: return acc + (ux * uy);
      4'd11: return acc - (sx * sy);
      4'd12: return acc - (ux * uy);
      default: return acc;
    endcase
  endfunction

  task automatic idle_inputs();
    start = 1'b0;
    md_op = MD_NONE;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic run_long(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit inject);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    int n, busy_cnt;
    bit e_busy, lng;
    lng    = model_long(op);
    old_hi = m_hi;
    old_lo = m_lo;
    exp    = lng ? ref_md(op, x, y, m_hi, m_lo) : {m_hi, m_lo};
    n      = !lng ? 0 : ((op == 4'd3 || op == 4'd4) ? DC : MC);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y; md_d = 1'($urandom_range(0, 1));
    #1;
    check("issue_busy", busy, lng);
    check("issue_stall", stall_md, md_d & lng);
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (inject && c <= n) begin
        start = 1'b1; md_op = MD_MULT; a = $urandom; b = $urandom;
      end else begin
        idle_inputs();
      end
      md_d = 1'($urandom_range(0, 1));
      #1;
      e_busy = (c <= n);
      check("run_busy", busy, e_busy);
      check("run_stall", stall_md, md_d & e_busy);
      if (busy === 1'b1) busy_cnt++;
      if (c == n && n > 0) check("pre_commit_hilo", {hi, lo}, {old_hi, old_lo});
      if (c == n + 1) begin
        check("commit_hi", hi, exp[63:32]);
        check("commit_lo", lo, exp[31:0]);
      end
    end
    check("busy_cycles", busy_cnt, lng ? n + 1 : 0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    @(negedge clk);
    start = 1'b1; md_op = op; a = val; md_d = 1'b1;
    #1;
    check("mt_busy", busy, 1'b0);
    if (op == MD_MTHI) m_hi = val; else m_lo = val;
    @(negedge clk);
    start = 1'b1; md_op = (op == MD_MTHI) ? MD_MFHI : MD_MFLO; a = $urandom;
    #1;
    check("mt_then_mf", rdata, val);
    idle_inputs();
  endtask

  task automatic read_check();
    @(negedge clk);
    start = 1'b1; md_op = MD_MFHI;
    #1;
    check("mfhi", rdata, m_hi);
    md_op = MD_MFLO;
    #1;
    check("mflo", rdata, m_lo);
    md_op = MD_NONE;
    #1;
    check("rdata_none", rdata, 32'd0);
    idle_inputs();
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; md_op = MD_MFHI; a = 32'd0; b = 32'd0; md_d = 1'b1;
    #12;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall_md, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    md_op = MD_NONE;

    run_long(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_ref_hi", m_hi, 32'hFFFF_FFFF);
    run_long(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("multu_ref_hi", m_hi, 32'h0000_0002);
    run_long(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_ref_lo", m_lo, 32'hFFFF_FFFD);
    run_long(MD_DIV, 32'd7, 32'd0, 1'b0);
    run_long(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", m_lo, 32'h8000_0000);
    read_check();
    mt(MD_MTHI, 32'h1234_5678);
    mt(MD_MTLO, 32'h9ABC_DEF0);

    // Reset in the third cycle of a divide: nothing commits afterwards.
    @(negedge clk);
    start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7; md_d = 1'b0;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_hi", hi, 32'd0);
    check("midrun_rst_lo", lo, 32'd0);
    check("midrun_rst_busy", busy, 1'b0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DC + 3) @(negedge clk);
    #1;
    check("post_rst_hilo", {hi, lo}, 64'd0);
    check("post_rst_busy", busy, 1'b0);

    mt(MD_MTHI, 32'd0);
    mt(MD_MTLO, 32'hFFFF_FFFF);
    run_long(MD_MADDU, 32'd1, 32'd1, 1'b0);
    read_check();

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 13));
      x  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == MD_MTHI || op == MD_MTLO) mt(op, x);
      else if (op == MD_MFHI || op == MD_MFLO) read_check();
      else run_long(op, x, y, 1'($urandom_range(0, 1)));
    end
    read_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
